pyramid_scan_ctrl: RTL and testbench

Parametrised scanning-window sequencer for the Viola-Jones detector. After a start pulse it waits a fixed settle interval for the integral images to become valid. It then walks every enabled pyramid level in raster order and emits one (level, row, col) window coordinate per accepted handshake to the vj_pipeline front end. Generalises the fixed 10-level, stride-1, free-running scan loop with configurable level geometry, window stride, per-level enable mask, backpressure and abort.

---
 rtl/pyramid_scan_ctrl_if.sv | 15 +
 rtl/pyramid_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pyramid_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pyramid_scan_ctrl_if.sv
// Window-coordinate handshake between the scan sequencer (master) and the
// vj_pipeline front end (slave).
interface pyramid_scan_ctrl_if #(
  parameter int COORD_W = 16
);
  logic               win_valid;
  logic               win_ready;
  logic [3:0]         level;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;
  logic               last_win;

  modport master (output win_valid, level, row, col, last_win, input win_ready);
  modport slave  (input win_valid, level, row, col, last_win, output win_ready);
endinterface

// File: rtl/pyramid_scan_ctrl.sv
// Viola-Jones scanning-window sequencer: settle after start, then walk every
// enabled, large-enough pyramid level in raster order, one window per handshake.
module pyramid_scan_ctrl #(
  parameter int                        LEVELS        = 10,
  parameter int                        WINDOW_SIZE   = 24,
  parameter int                        STRIDE        = 1,
  parameter logic [LEVELS-1:0][15:0]   LEVEL_WIDTHS  = {16'd43, 16'd54, 16'd67, 16'd84, 16'd105,
                                                        16'd131, 16'd164, 16'd204, 16'd256, 16'd320},
  parameter logic [LEVELS-1:0][15:0]   LEVEL_HEIGHTS = {16'd32, 16'd40, 16'd50, 16'd63, 16'd78,
                                                        16'd98, 16'd123, 16'd153, 16'd192, 16'd240},
  parameter int                        SETTLE_CYCLES = 76800,
  parameter int                        COORD_W       = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [LEVELS-1:0]   level_en,
  pyramid_scan_ctrl_if.master win,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SCAN, S_DONE} state_e;

  // Last legal top-left coordinate per level: largest stride multiple <= dim-WINDOW_SIZE.
  function automatic logic [LEVELS-1:0][15:0] last_tbl(input logic [LEVELS-1:0][15:0] dims);
    logic [LEVELS-1:0][15:0] t;
    for (int i = 0; i < LEVELS; i++) begin
      if (int'(dims[i]) >= WINDOW_SIZE)
        t[i] = 16'(((int'(dims[i]) - WINDOW_SIZE) / STRIDE) * STRIDE);
      else
        t[i] = 16'd0;
    end
    return t;
  endfunction

  function automatic logic [LEVELS-1:0] fits_tbl();
    logic [LEVELS-1:0] t;
    for (int i = 0; i < LEVELS; i++)
      t[i] = (int'(LEVEL_WIDTHS[i]) >= WINDOW_SIZE) && (int'(LEVEL_HEIGHTS[i]) >= WINDOW_SIZE);
    return t;
  endfunction

  localparam logic [LEVELS-1:0][15:0] COL_LAST_TBL = last_tbl(LEVEL_WIDTHS);
  localparam logic [LEVELS-1:0][15:0] ROW_LAST_TBL = last_tbl(LEVEL_HEIGHTS);
  localparam logic [LEVELS-1:0]       LEVEL_FITS   = fits_tbl();

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LEVELS-1:0]  mask_q, mask_d;
  logic [3:0]         level_q, level_d;
  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;

  logic [LEVELS-1:0]  usable;
  logic               first_found, above_found;
  logic [3:0]         first_idx, above_idx;
  logic [COORD_W-1:0] col_last, row_last;
  logic               at_col_end, at_row_end;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    usable      = mask_q & LEVEL_FITS;
    first_found = 1'b0;
    first_idx   = '0;
    above_found = 1'b0;
    above_idx   = '0;
    col_last    = '0;
    row_last    = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (!first_found && usable[i]) begin
        first_found = 1'b1;
        first_idx   = 4'(i);
      end
      if (!above_found && usable[i] && (4'(i) > level_q)) begin
        above_found = 1'b1;
        above_idx   = 4'(i);
      end
      if (level_q == 4'(i)) begin
        col_last = COORD_W'(COL_LAST_TBL[i]);
        row_last = COORD_W'(ROW_LAST_TBL[i]);
      end
    end
    at_col_end = (col_q == col_last);
    at_row_end = (row_q == row_last);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    level_d = level_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = level_en;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          if (first_found) begin
            state_d = S_SCAN;
            level_d = first_idx;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SCAN: begin
        if (win.win_ready) begin
          if (!at_col_end) begin
            col_d = col_q + COORD_W'(STRIDE);
          end else if (!at_row_end) begin
            col_d = '0;
            row_d = row_q + COORD_W'(STRIDE);
          end else if (above_found) begin
            level_d = above_idx;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over start and over a same-cycle handshake.
    if (abort) state_d = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      level_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      level_q <= level_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Outputs decode registered state only; win_ready never reaches win_valid.
  assign win.win_valid = (state_q == S_SCAN);
  assign win.level     = level_q;
  assign win.row       = row_q;
  assign win.col       = col_q;
  assign win.last_win  = (state_q == S_SCAN) && at_col_end && at_row_end && !above_found;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

endmodule

// File: tb/tb_pyramid_scan_ctrl.sv
// Directed bench for pyramid_scan_ctrl: two small-geometry instances
// (stride 1 and stride 2) sharing one clock, reset and control inputs.
module tb_pyramid_scan_ctrl;

  localparam int LV = 3;
  localparam logic [LV-1:0][15:0] W = {16'd3, 16'd4, 16'd6};
  localparam logic [LV-1:0][15:0] H = {16'd8, 16'd4, 16'd5};

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start1 = 1'b0, start2 = 1'b0, abort = 1'b0, win_ready = 1'b1;
  logic [LV-1:0] level_en = 3'b111;
  logic          busy1, done1, busy2, done2;

  pyramid_scan_ctrl_if #(.COORD_W(16)) if1 ();
  pyramid_scan_ctrl_if #(.COORD_W(16)) if2 ();
  assign if1.win_ready = win_ready;
  assign if2.win_ready = win_ready;

  pyramid_scan_ctrl #(.LEVELS(LV), .WINDOW_SIZE(4), .STRIDE(1), .LEVEL_WIDTHS(W),
                      .LEVEL_HEIGHTS(H), .SETTLE_CYCLES(3), .COORD_W(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .abort(abort),
    .level_en(level_en), .win(if1), .busy(busy1), .done(done1));

  pyramid_scan_ctrl #(.LEVELS(LV), .WINDOW_SIZE(4), .STRIDE(2), .LEVEL_WIDTHS(W),
                      .LEVEL_HEIGHTS(H), .SETTLE_CYCLES(3), .COORD_W(16)) dut2 (
    .clock(clock), .reset_n(reset_n), .start(start2), .abort(abort),
    .level_en(level_en), .win(if2), .busy(busy2), .done(done2));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int sel = 0;

  logic        o_valid, o_last, o_busy, o_done;
  logic [3:0]  o_lvl;
  logic [15:0] o_row, o_col;

  always_comb begin
    if (sel == 0) begin
      o_valid = if1.win_valid; o_last = if1.last_win; o_lvl = if1.level;
      o_row = if1.row; o_col = if1.col; o_busy = busy1; o_done = done1;
    end else begin
      o_valid = if2.win_valid; o_last = if2.last_win; o_lvl = if2.level;
      o_row = if2.row; o_col = if2.col; o_busy = busy2; o_done = done2;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef logic [36:0] win_t;
  function automatic win_t mk(input int l, input int r, input int c, input int last);
    return {4'(l), 16'(r), 16'(c), 1'(last)};
  endfunction

  win_t got[$];
  win_t expq[$];
  int   lat, done_k, last_k, done_cnt, stall_left, stall_seen;
  bit   stall_mode = 1'b0;

  // Pulse start on the selected instance and log every handshaken window.
  task automatic run_frame(input int which, input int budget);
    bit finished;
    got.delete();
    lat = -1; done_k = -1; last_k = -1; done_cnt = 0; stall_seen = 0;
    finished = 1'b0;
    sel = which;
    if (which == 0) start1 = 1'b1; else start2 = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      step();
      start1 = 1'b0;
      start2 = 1'b0;
      win_ready = 1'b1;
      if (stall_mode && o_valid && o_lvl == 4'd0 && o_row == 16'd1 && o_col == 16'd1 &&
          stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
        stall_seen++;
      end
      if (o_valid && lat < 0) lat = k;
      if (o_valid && win_ready) begin
        got.push_back({o_lvl, o_row, o_col, o_last});
        last_k = k;
      end
      if (o_done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (done_cnt > 0 && !o_busy) begin
        finished = 1'b1;
        break;
      end
    end
    win_ready = 1'b1;
    check("frame_finished", 64'(finished), 64'd1);
  endtask

  task automatic compare_windows(input string tag);
    check({tag, "_count"}, 64'(got.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      check($sformatf("%s_win%0d", tag, i), 64'(got[i]), 64'(expq[i]));
  endtask

  task automatic expect_full_stride1();
    expq = '{mk(0,0,0,0), mk(0,0,1,0), mk(0,0,2,0), mk(0,1,0,0), mk(0,1,1,0), mk(0,1,2,0),
             mk(1,0,0,1)};
  endtask

  initial begin
    bit seen_done;
    bit found;

    // Reset state
    #12;
    check("rst_valid", 64'(if1.win_valid), 64'd0);
    check("rst_busy", 64'(busy1), 64'd0);
    check("rst_done", 64'(done1), 64'd0);
    check("rst_coords", 64'({if1.level, if1.row, if1.col, if1.last_win}), 64'd0);
    reset_n = 1'b1;
    step();

    // 1: full stride-1 scan, level 2 too narrow
    run_frame(0, 40);
    expect_full_stride1();
    compare_windows("t1");
    check("t1_latency", 64'(lat), 64'd4);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_done_after_last", 64'(done_k), 64'(last_k + 1));
    check("t1_idle_valid", 64'(o_valid), 64'd0);

    // 2: stride 2
    run_frame(1, 40);
    expq = '{mk(0,0,0,0), mk(0,0,2,0), mk(1,0,0,1)};
    compare_windows("t2");
    check("t2_latency", 64'(lat), 64'd4);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);

    // 3: only level 1 enabled
    level_en = 3'b010;
    run_frame(0, 40);
    expq = '{mk(1,0,0,1)};
    compare_windows("t3");
    check("t3_done_k", 64'(done_k), 64'd5);
    level_en = 3'b111;

    // 4: backpressure on L0 (1,1) for five cycles
    stall_mode = 1'b1;
    stall_left = 5;
    run_frame(0, 60);
    stall_mode = 1'b0;
    expect_full_stride1();
    compare_windows("t4");
    check("t4_stall_cycles", 64'(stall_seen), 64'd5);

    // 5a: abort during SETTLE
    sel = 0;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    check("t5a_in_settle", 64'({o_busy, o_valid}), 64'b10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5a_busy", 64'(o_busy), 64'd0);
    check("t5a_valid", 64'(o_valid), 64'd0);
    check("t5a_done", 64'(o_done), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (o_done || o_valid) seen_done = 1'b1;
    end
    check("t5a_quiet", 64'(seen_done), 64'd0);

    // 5b: abort during SCAN at L0 (0,2)
    start1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      start1 = 1'b0;
      if (o_valid && o_col == 16'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("t5b_reached_0_2", 64'({found, o_lvl, o_row}), 64'({1'b1, 4'd0, 16'd0}));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5b_busy", 64'(o_busy), 64'd0);
    check("t5b_valid", 64'(o_valid), 64'd0);
    check("t5b_done", 64'(o_done), 64'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_done) seen_done = 1'b1;
    end
    check("t5b_no_done", 64'(seen_done), 64'd0);
    run_frame(0, 40);
    expect_full_stride1();
    compare_windows("t5_rescan");

    // 6: asynchronous reset mid-scan, then an empty-mask frame
    start1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      start1 = 1'b0;
      if (o_valid && o_row == 16'd1 && o_col == 16'd1) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reached_1_1", 64'(found), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_valid", 64'(o_valid), 64'd0);
    check("t6_async_busy", 64'(o_busy), 64'd0);
    check("t6_async_coords", 64'({o_lvl, o_row, o_col, o_last, o_done}), 64'd0);
    #2;
    reset_n = 1'b1;
    level_en = 3'b000;
    step();
    run_frame(0, 20);
    check("t6_no_windows", 64'(got.size()), 64'd0);
    check("t6_no_valid", 64'(lat), 64'(-1));
    check("t6_done_k", 64'(done_k), 64'd4);
    check("t6_done_cnt", 64'(done_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
